// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern-detect controller.
// Holds the FSM state encoding and a saturating increment helper.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      DRAIN  = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam int          DEF_WORD_W  = 8;
   localparam int          DEF_PAT_W   = 4;
   localparam logic [3:0]  DEF_PATTERN = 4'b1001;
   localparam int          DEF_CNT_W   = 4;

   function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic [15:0] max);
      return (value >= max) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/seq_pattern_det.sv
// Serial pattern detector: keeps the last PAT_W-1 bits plus a fill count
// and registers a match when the newest bit completes PATTERN.
module seq_pattern_det
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic bit_valid,
   input  logic bit_in,
   output logic match
);

   localparam int                FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  hist;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  window;
   logic              filled;

   assign window = {hist, bit_in};
   assign filled = (fill == FULL);

   // Clear has priority over a bit arriving on the same edge, so a fresh
   // word never sees history from the word before it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist  <= '0;
         fill  <= '0;
         match <= 1'b0;
      end else if (clear) begin
         hist  <= '0;
         fill  <= '0;
         match <= 1'b0;
      end else begin
         match <= bit_valid && filled && (window == PATTERN);
         if (bit_valid) begin
            hist <= window[PAT_W-2:0];
            if (!filled) fill <= fill + FILL_W'(1);
         end
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-level controller: serialises words MSB-first into seq_pattern_det and
// reports per-word match counts. Optional feature macro: SEQ_CTRL_STATS_EN.
module seq_detect_ctrl
   import seq_det_pkg::*;
#(
   parameter int               WORD_W  = DEF_WORD_W,
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
   parameter int               CNT_W   = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_cont,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_hit,
   output logic              busy
`ifdef SEQ_CTRL_STATS_EN
   ,
   output logic [15:0]       total_matches
`endif
);

   localparam int          IDX_W   = $clog2(WORD_W);
   localparam logic [15:0] CNT_MAX = 16'((32'd1 << CNT_W) - 1);

   state_t            state, state_next;
   logic [WORD_W-1:0] word_q;
   logic [IDX_W-1:0]  idx;
   logic              accept;
   logic              det_clear;
   logic              bit_valid;
   logic              match;
   logic [CNT_W-1:0]  count_inc;

   assign in_ready  = (state == IDLE) && !reset;
   assign accept    = in_valid && in_ready;
   assign det_clear = accept && !in_cont;
   assign bit_valid = (state == SHIFT);
   assign busy      = (state != IDLE);
   assign out_hit   = (out_count != '0);
   assign count_inc = CNT_W'(sat_inc(16'(out_count), CNT_MAX));

   seq_pattern_det #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_det (
      .clk       (clk),
      .reset     (reset),
      .clear     (det_clear),
      .bit_valid (bit_valid),
      .bit_in    (word_q[WORD_W-1]),
      .match     (match)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SHIFT;
         SHIFT:   if (idx == '0) state_next = DRAIN;
         DRAIN:   state_next = REPORT;
         REPORT:  if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The detector's match lags its bit by one edge, so SHIFT adds the
   // previous bit's match and DRAIN picks up the last one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q    <= '0;
         idx       <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  word_q    <= in_data;
                  idx       <= IDX_W'(WORD_W - 1);
                  out_count <= '0;
               end
            end
            SHIFT: begin
               word_q <= word_q << 1;
               idx    <= idx - IDX_W'(1);
               if (match) out_count <= count_inc;
            end
            DRAIN: begin
               if (match) out_count <= count_inc;
               out_valid <= 1'b1;
            end
            REPORT: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef SEQ_CTRL_STATS_EN
   // Accumulates raw matches, so it keeps counting past a saturated out_count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         total_matches <= '0;
      else if ((state == SHIFT || state == DRAIN) && match)
         total_matches <= sat_inc(total_matches, 16'hFFFF);
   end
`endif

endmodule
